// File: rtl/apple_place_ctrl_if.sv
// Handshake and body-memory bundle between game logic and the apple placer.
// The master side raises req and serves the body memory; the slave side is
// the placer, which drives the body address and the committed apple cell.
interface apple_place_ctrl_if #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5,
  parameter int LEN_WIDTH     = 10
);
  logic                     req;
  logic [LEN_WIDTH-1:0]     length;
  logic [LEN_WIDTH-1:0]     body_addr;
  logic [H_LOGIC_WIDTH-1:0] body_x;
  logic [V_LOGIC_WIDTH-1:0] body_y;
  logic [H_LOGIC_WIDTH-1:0] appleX;
  logic [V_LOGIC_WIDTH-1:0] appleY;
  logic                     busy;
  logic                     done;
  logic                     fail;
  logic [6:0]               tries;

  modport master (
    output req, length, body_x, body_y,
    input  body_addr, appleX, appleY, busy, done, fail, tries
  );

  modport slave (
    input  req, length, body_x, body_y,
    output body_addr, appleX, appleY, busy, done, fail, tries
  );
endinterface

// File: rtl/apple_place_ctrl.sv
// Apple placement sequencer: draws grid cells from a free-running LFSR,
// rejects off-grid draws, then scans the snake body through a one-cycle
// read port and retries on any overlap. Gives up after MAX_TRIES draws.
module apple_place_ctrl #(
  parameter int                       H_LOGIC_WIDTH = 5,
  parameter int                       V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = 5'd23,
  parameter int                       LEN_WIDTH     = 10,
  parameter int                       MAX_TRIES     = 64,
  parameter logic [15:0]              LFSR_SEED     = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  apple_place_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRAW, SCAN, COMMIT, FAIL} state_t;

  localparam logic [6:0]           TRIES_MAX = 7'(MAX_TRIES);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  state_t                   state;
  logic [15:0]              lfsr;
  logic [H_LOGIC_WIDTH-1:0] cand_x;
  logic [V_LOGIC_WIDTH-1:0] cand_y;
  logic [H_LOGIC_WIDTH-1:0] apple_x;
  logic [V_LOGIC_WIDTH-1:0] apple_y;
  logic [LEN_WIDTH-1:0]     addr;
  logic [6:0]               tries;
  logic                     busy;
  logic                     done;
  logic                     fail;
  // cmp_valid: read data returned this cycle belongs to an issued address.
  // cmp_last: that returned data is for index length-1.
  logic                     cmp_valid;
  logic                     cmp_last;

  logic                     lfsr_fb;
  logic [H_LOGIC_WIDTH-1:0] draw_x;
  logic [V_LOGIC_WIDTH-1:0] draw_y;
  logic                     draw_legal;
  logic                     hit;
  logic                     addr_last;

  // Taps 16,14,13,11 in right-shift form; the new bit enters at the top.
  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign draw_x     = lfsr[H_LOGIC_WIDTH-1:0];
  assign draw_y     = lfsr[8 +: V_LOGIC_WIDTH];
  assign draw_legal = (int'(draw_x) <= int'(H_LOGIC_MAX)) &&
                      (int'(draw_y) <= int'(V_LOGIC_MAX));
  assign hit        = (bus.body_x == cand_x) && (bus.body_y == cand_y);
  assign addr_last  = (addr == bus.length - LEN_ONE);

  assign bus.body_addr = addr;
  assign bus.appleX    = apple_x;
  assign bus.appleY    = apple_y;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.fail      = fail;
  assign bus.tries     = tries;

  // Free-running LFSR: advances every cycle regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr_fb, lfsr[15:1]};
  end

  // Placement FSM with registered outputs; done/busy/apple change on the
  // edge that enters COMMIT or FAIL so they are visible in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      apple_x   <= H_LOGIC_WIDTH'(3);
      apple_y   <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      addr      <= '0;
      tries     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state <= DRAW;
            busy  <= 1'b1;
            fail  <= 1'b0;
            tries <= '0;
          end
        end
        DRAW: begin
          if (tries == TRIES_MAX) begin
            // Budget spent; tries stays saturated at MAX_TRIES.
            state <= FAIL;
            done  <= 1'b1;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cand_x <= draw_x;
            cand_y <= draw_y;
            tries  <= tries + 7'd1;
            if (!draw_legal) begin
              state <= DRAW;
            end else if (bus.length == '0) begin
              state   <= COMMIT;
              apple_x <= draw_x;
              apple_y <= draw_y;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state     <= SCAN;
              addr      <= '0;
              cmp_valid <= 1'b0;
              cmp_last  <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (cmp_valid && hit) begin
            // Collision: abandon the scan, any in-flight read is dropped.
            state <= DRAW;
          end else if (cmp_valid && cmp_last) begin
            state   <= COMMIT;
            apple_x <= cand_x;
            apple_y <= cand_y;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cmp_valid <= 1'b1;
            cmp_last  <= addr_last;
            if (!addr_last) addr <= addr + LEN_ONE;
          end
        end
        COMMIT, FAIL: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_place_ctrl.sv
// Self-checking bench for apple_place_ctrl: a table of placement scenarios,
// directed multi-cycle corner cases and random placements, all checked
// against a draw-by-draw timing model of the placement rules.
module tb_apple_place_ctrl;

  localparam int X_MAX = 31;
  localparam int Y_MAX = 23;

  logic clk;
  logic rst;

  apple_place_ctrl_if #(.H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5), .LEN_WIDTH(10)) bus ();

  apple_place_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Body memory with one-cycle registered read
  logic [4:0] bx [1024];
  logic [4:0] by [1024];
  always @(posedge clk) begin
    bus.body_x <= bx[bus.body_addr];
    bus.body_y <= by[bus.body_addr];
  end

  function automatic logic [15:0] step(input logic [15:0] l);
    logic b;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {b, l[15:1]};
  endfunction

  function automatic logic [15:0] stepn(input logic [15:0] l, input int n);
    logic [15:0] r;
    r = l;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  // LFSR value of the current cycle, reseeded by reset
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);
  end

  function automatic bit legal(input logic [15:0] l);
    return (int'(l[4:0]) <= X_MAX) && (int'(l[12:8]) <= Y_MAX);
  endfunction

  function automatic bit in_body(input int x, input int y, input int len);
    for (int i = 0; i < len; i++)
      if (int'(bx[i]) == x && int'(by[i]) == y) return 1'b1;
    return 1'b0;
  endfunction

  int cur_ax = 3;
  int cur_ay = 0;

  // Reference: offset 0 is the first DRAW cycle, whose LFSR value is l_in.
  task automatic predict(input logic [15:0] l_in, input int len,
                         output int px, output int py, output int pt,
                         output bit pf, output int poff);
    logic [15:0] l;
    int t, x, y, h;
    l = l_in; t = 0; pt = 0; pf = 1'b0; px = cur_ax; py = cur_ay; poff = 0;
    for (int guard = 0; guard < 200; guard++) begin
      if (pt == 64) begin pf = 1'b1; poff = t + 1; return; end
      pt++;
      x = int'(l[4:0]);
      y = int'(l[12:8]);
      if (x > X_MAX || y > Y_MAX) begin t++; l = step(l); continue; end
      h = -1;
      for (int i = 0; i < len; i++)
        if (int'(bx[i]) == x && int'(by[i]) == y) begin h = i; break; end
      if (h < 0) begin
        px = x; py = y;
        poff = (len == 0) ? t + 1 : t + len + 2;
        return;
      end
      t += h + 3;
      l = stepn(l, h + 3);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_appleX"}, 32'(bus.appleX), 3);
    chk({tag, "_appleY"}, 32'(bus.appleY), 0);
    chk({tag, "_busy"},   32'(bus.busy),   0);
    chk({tag, "_done"},   32'(bus.done),   0);
    chk({tag, "_fail"},   32'(bus.fail),   0);
    chk({tag, "_tries"},  32'(bus.tries),  0);
    chk({tag, "_addr"},   32'(bus.body_addr), 0);
  endtask

  int   last_off, last_px, last_py, last_pt;
  bit   last_pf, addr_moved;
  int   addr_log [16];

  // One placement: req sampled at the next edge, then run to done.
  task automatic do_place(input string name, input int len);
    int px, py, pt, poff, off;
    bit pf, stable_ok;
    logic [9:0] a0;
    bus.length = 10'(len);
    bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    predict(m_lfsr, len, px, py, pt, pf, poff);
    chk({name, "_busy_rise"}, 32'(bus.busy), 1);
    off = 0; stable_ok = 1'b1; addr_moved = 1'b0; a0 = bus.body_addr;
    while (bus.done !== 1'b1 && off < poff + 20) begin
      if (int'(bus.appleX) != cur_ax || int'(bus.appleY) != cur_ay) stable_ok = 1'b0;
      if (off < 16) addr_log[off] = int'(bus.body_addr);
      if (bus.body_addr != a0) addr_moved = 1'b1;
      @(posedge clk); #1;
      off++;
    end
    chk({name, "_done_cycle"}, off, poff);
    chk({name, "_appleX"}, 32'(bus.appleX), px);
    chk({name, "_appleY"}, 32'(bus.appleY), py);
    chk({name, "_tries"},  32'(bus.tries),  pt);
    chk({name, "_fail"},   32'(bus.fail),   32'(pf));
    chk({name, "_busy_fall"}, 32'(bus.busy), 0);
    chk({name, "_apple_stable"}, 32'(stable_ok), 1);
    $display("place %s len=%0d draws=%0d fail=%0d apple=(%0d,%0d) cycles=%0d",
             name, len, pt, pf, px, py, off);
    last_off = off; last_px = px; last_py = py; last_pt = pt; last_pf = pf;
    cur_ax = px; cur_ay = py;
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  // Wait until the next draw is legal and free of the first len segments
  task automatic wait_free_draw(input int len);
    logic [15:0] l1;
    for (int i = 0; i < 2000; i++) begin
      l1 = step(m_lfsr);
      if (legal(l1) && !in_body(int'(l1[4:0]), int'(l1[12:8]), len)) return;
      @(posedge clk); #1;
    end
    chk("search_free_timeout", 0, 1);
  endtask

  typedef struct {
    int length;
    int kind;      // 0 none, 1 row y=0, 2 full grid, 3 diagonal
    int exp_fail;
    int exp_tries; // -1: taken from the model only
  } vec_t;

  vec_t vecs [6];
  int   apple_ax, apple_ay;

  initial begin
    logic [15:0] l1, l2;
    int x1, y1, x2, y2, c;

    vecs[0] = '{0,   0, 0, -1};
    vecs[1] = '{1,   1, 0, -1};
    vecs[2] = '{3,   3, 0, -1};
    vecs[3] = '{32,  1, 0, -1};
    vecs[4] = '{100, 3, 0, -1};
    vecs[5] = '{768, 2, 1, 64};

    for (int i = 0; i < 1024; i++) begin bx[i] = '0; by[i] = '0; end
    bus.req = 1'b0;
    bus.length = '0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1 check_reset("reset_async");
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // length 0 right after reset: reference for the reseed check later
    do_place("len0", 0);
    chk("len0_no_addr", 32'(addr_moved), 0);
    apple_ax = last_px;
    apple_ay = last_py;

    // Scenario table
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].length; i++) begin
        case (vecs[v].kind)
          1: begin bx[i] = 5'(i % 32); by[i] = 5'd0; end
          2: begin bx[i] = 5'(i % 32); by[i] = 5'(i / 32); end
          3: begin bx[i] = 5'(i % 32); by[i] = 5'(i % 24); end
          default: begin bx[i] = 5'd0; by[i] = 5'd0; end
        endcase
      end
      do_place($sformatf("vec%0d", v), vecs[v].length);
      chk($sformatf("vec%0d_fail_tbl", v), 32'(bus.fail), vecs[v].exp_fail);
      if (vecs[v].exp_tries >= 0)
        chk($sformatf("vec%0d_tries_tbl", v), 32'(bus.tries), vecs[v].exp_tries);
    end

    // length 4 on row 0: address sequence and latency
    for (int i = 0; i < 4; i++) begin bx[i] = 5'(i); by[i] = 5'd0; end
    wait_free_draw(4);
    do_place("len4", 4);
    for (int i = 0; i < 4; i++) chk($sformatf("len4_addr%0d", i), addr_log[i + 1], i);
    chk("len4_latency", last_off, 6);
    chk("len4_tries1", 32'(bus.tries), 1);

    // Collision at segment 2 of 5, second draw commits
    begin : coll_search
      for (int i = 0; i < 2000; i++) begin
        l1 = step(m_lfsr);
        l2 = stepn(l1, 5);
        if (legal(l1) && legal(l2) && (l1[4:0] != l2[4:0] || l1[12:8] != l2[12:8]))
          disable coll_search;
        @(posedge clk); #1;
      end
      chk("search_coll_timeout", 0, 1);
    end
    x1 = int'(l1[4:0]); y1 = int'(l1[12:8]);
    x2 = int'(l2[4:0]); y2 = int'(l2[12:8]);
    c = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bx[i] = 5'(x1); by[i] = 5'(y1); continue; end
      while ((c % 32 == x1 && c / 32 == y1) || (c % 32 == x2 && c / 32 == y2)) c++;
      bx[i] = 5'(c % 32); by[i] = 5'(c / 32);
      c++;
    end
    do_place("coll", 5);
    chk("coll_tries2", 32'(bus.tries), 2);
    chk("coll_latency", last_off, 12);
    chk("coll_appleX2", 32'(bus.appleX), x2);
    chk("coll_appleY2", 32'(bus.appleY), y2);
    chk("coll_not_in_body", 32'(in_body(int'(bus.appleX), int'(bus.appleY), 5)), 0);

    // Random placements
    for (int r = 0; r < 20; r++) begin
      int len;
      len = int'($urandom_range(0, 24));
      for (int i = 0; i < len; i++) begin
        bx[i] = 5'($urandom_range(0, X_MAX));
        by[i] = 5'($urandom_range(0, Y_MAX));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_place($sformatf("rand%0d", r), len);
    end

    // req held 3 cycles while busy, then asynchronous reset mid-SCAN
    for (int i = 0; i < 20; i++) begin bx[i] = 5'(i); by[i] = 5'd0; end
    wait_free_draw(20);
    bus.length = 10'd20;
    bus.req = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_addr3", 32'(bus.body_addr), 3);
    chk("hold_tries1", 32'(bus.tries), 1);
    chk("hold_busy_scan", 32'(bus.busy), 1);
    chk("hold_no_done", 32'(bus.done), 0);
    $display("hold req 3 cycles, scan at addr %0d, asserting reset", bus.body_addr);
    #2 rst = 1'b1;
    #1 check_reset("reset_midscan");
    cur_ax = 3; cur_ay = 0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_place("reseed", 0);
    chk("reseed_sameX", 32'(bus.appleX), apple_ax);
    chk("reseed_sameY", 32'(bus.appleY), apple_ay);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
